// File: rtl/scaler_pkg.sv
// Shared constants and pipeline payload for the horizontal video scaler.
package scaler_pkg;

  localparam int unsigned POS_WIDTH       = 24;
  localparam int unsigned DEF_PIXEL_STEP  = 32;
  localparam int unsigned DEF_PIXEL_WIDTH = 8;
  localparam int unsigned DEF_COE_WIDTH   = 8;

  // Turns a position fraction (0..PIXEL_STEP] into a coefficient (0..2^COE_WIDTH].
  localparam int unsigned COE_SHIFT = $clog2((2 ** DEF_COE_WIDTH) / DEF_PIXEL_STEP);

  typedef struct packed {
    logic                       de;
    logic                       hs;
    logic                       vs;
    logic [DEF_PIXEL_WIDTH-1:0] prev;
    logic [DEF_PIXEL_WIDTH-1:0] cur;
    logic [DEF_COE_WIDTH:0]     coe;
  } stage_t;

endpackage

// File: rtl/scaler_h_lerp.sv
// Two-stage weighted sum of neighbouring pixels with round-half-up.
module scaler_h_lerp #(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned COE_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_de,
  input  logic                   i_hs,
  input  logic                   i_vs,
  input  logic [PIXEL_WIDTH-1:0] i_prev,
  input  logic [PIXEL_WIDTH-1:0] i_cur,
  input  logic [COE_WIDTH:0]     i_coe,
  output logic [PIXEL_WIDTH-1:0] o_do,
  output logic                   o_de,
  output logic                   o_hs,
  output logic                   o_vs
);

  localparam int unsigned PROD_W = PIXEL_WIDTH + COE_WIDTH + 1;
  localparam int unsigned SUM_W  = PIXEL_WIDTH + COE_WIDTH + 2;
  localparam logic [COE_WIDTH:0] COE_ONE  = {1'b1, {COE_WIDTH{1'b0}}};
  localparam logic [SUM_W-1:0]   ROUND_HALF = SUM_W'(COE_ONE >> 1);

  logic [PROD_W-1:0] r_p0;
  logic [PROD_W-1:0] r_p1;
  logic              r_de;
  logic              r_hs;
  logic              r_vs;
  logic [SUM_W-1:0]  w_sum;

  always_comb begin
    w_sum = SUM_W'(r_p0) + SUM_W'(r_p1) + ROUND_HALF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p0 <= '0;
      r_p1 <= '0;
      r_de <= 1'b0;
      r_hs <= 1'b0;
      r_vs <= 1'b0;
      o_do <= '0;
      o_de <= 1'b0;
      o_hs <= 1'b0;
      o_vs <= 1'b0;
    end else begin
      r_p0 <= PROD_W'(i_prev) * PROD_W'(COE_ONE - i_coe);
      r_p1 <= PROD_W'(i_cur) * PROD_W'(i_coe);
      r_de <= i_de;
      r_hs <= i_hs;
      r_vs <= i_vs;
      o_de <= r_de;
      o_hs <= r_hs;
      o_vs <= r_vs;
      // Output pixel holds between emits.
      if (r_de) begin
        o_do <= PIXEL_WIDTH'(w_sum >> COE_WIDTH);
      end
    end
  end

endmodule

// File: rtl/video_scaler_h.sv
// Horizontal downscaler: tracks input/output positions per line and feeds the
// interpolation datapath; sync signals ride along with fixed latency.
module video_scaler_h
  import scaler_pkg::*;
#(
  parameter int unsigned PIXEL_STEP  = DEF_PIXEL_STEP,
  parameter int unsigned PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int unsigned COE_WIDTH   = DEF_COE_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            scale_step_h,
  input  logic [PIXEL_WIDTH-1:0] di_i,
  input  logic                   de_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o
);

  localparam logic [POS_WIDTH-1:0] STEP_ONE = POS_WIDTH'(PIXEL_STEP);

  logic [POS_WIDTH-1:0]   r_xpos;
  logic [POS_WIDTH-1:0]   r_acc;
  logic [POS_WIDTH-1:0]   r_step;
  logic [PIXEL_WIDTH-1:0] r_prev;
  stage_t                 r_s1;

  logic                   w_sol;
  logic [POS_WIDTH-1:0]   w_step;
  logic [POS_WIDTH-1:0]   w_xpos;
  logic [POS_WIDTH-1:0]   w_acc;
  logic [POS_WIDTH-1:0]   w_f;
  logic                   w_emit;
  logic [COE_WIDTH:0]     w_coe;

  // Start of line restarts both positions at zero and latches the ratio.
  always_comb begin
    w_sol  = hs_i & de_i;
    w_step = r_step;
    if (w_sol) begin
      w_step = (scale_step_h < 16'(PIXEL_STEP)) ? STEP_ONE : POS_WIDTH'(scale_step_h);
    end
    w_xpos = w_sol ? '0 : r_xpos;
    w_acc  = w_sol ? '0 : r_acc;
    w_emit = (w_acc <= w_xpos);
    w_f    = w_acc - w_xpos + STEP_ONE;
    w_coe  = (COE_WIDTH + 1)'(w_f) << COE_SHIFT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_xpos <= '0;
      r_acc  <= '0;
      r_step <= STEP_ONE;
      r_prev <= '0;
      r_s1   <= '0;
    end else begin
      r_s1.de <= de_i & w_emit;
      r_s1.hs <= w_sol;
      r_s1.vs <= vs_i;
      if (de_i) begin
        r_s1.prev <= r_prev;
        r_s1.cur  <= di_i;
        r_s1.coe  <= w_coe;
        r_xpos    <= w_xpos + STEP_ONE;
        r_acc     <= w_emit ? (w_acc + w_step) : w_acc;
        r_prev    <= di_i;
        r_step    <= w_step;
      end
    end
  end

  scaler_h_lerp #(
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .COE_WIDTH   (COE_WIDTH)
  ) u_lerp (
    .clk    (clk),
    .rst    (rst),
    .i_de   (r_s1.de),
    .i_hs   (r_s1.hs),
    .i_vs   (r_s1.vs),
    .i_prev (r_s1.prev),
    .i_cur  (r_s1.cur),
    .i_coe  (r_s1.coe),
    .o_do   (do_o),
    .o_de   (de_o),
    .o_hs   (hs_o),
    .o_vs   (vs_o)
  );

endmodule

// File: tb/tb_video_scaler_h.sv
// Bench for video_scaler_h: position-based reference model, per-cycle compare.
module tb_video_scaler_h;

  localparam int N  = 16384;
  localparam int PS = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] scale_step_h = '0;
  logic [7:0]  di_i = '0;
  logic        de_i = 1'b0;
  logic        hs_i = 1'b0;
  logic        vs_i = 1'b0;
  logic [7:0]  do_o;
  logic        de_o;
  logic        hs_o;
  logic        vs_o;

  video_scaler_h dut (
    .clk          (clk),
    .rst          (rst),
    .scale_step_h (scale_step_h),
    .di_i         (di_i),
    .de_i         (de_i),
    .hs_i         (hs_i),
    .vs_i         (vs_i),
    .do_o         (do_o),
    .de_o         (de_o),
    .hs_o         (hs_o),
    .vs_o         (vs_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  bit         exp_de  [0:N-1];
  bit         exp_hs  [0:N-1];
  bit         exp_vs  [0:N-1];
  bit         exp_rst [0:N-1];
  logic [7:0] exp_do  [0:N-1];
  logic [7:0] got[$];
  logic [7:0] hold = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  // Expected output for every cycle, checked away from the active edge.
  always @(negedge clk) begin
    if (cyc < N) begin
      if (exp_rst[cyc]) hold = '0;
      if (exp_de[cyc])  hold = exp_do[cyc];
      if (cyc >= 2) begin
        chk("de_o", 32'(de_o), 32'(exp_de[cyc]));
        chk("hs_o", 32'(hs_o), 32'(exp_hs[cyc]));
        chk("vs_o", 32'(vs_o), 32'(exp_vs[cyc]));
        chk("do_o", 32'(do_o), 32'(hold));
      end
      if (de_o === 1'b1) got.push_back(do_o);
    end
  end

  // One input cycle plus what must appear on the outputs three cycles later.
  task automatic drive(input bit r, input bit d, input bit h, input bit v,
                       input logic [7:0] px, input logic [15:0] sc,
                       input bit e_de, input logic [7:0] e_do);
    int n;
    rst = r; de_i = d; hs_i = h; vs_i = v; di_i = px; scale_step_h = sc;
    n = cyc;
    if (n + 3 < N) begin
      exp_de[n+3] = e_de;
      exp_do[n+3] = e_do;
      exp_hs[n+3] = h & d;
      exp_vs[n+3] = v;
      if (r) begin
        for (int i = 1; i <= 3; i++) begin
          exp_de[n+i] = 1'b0;
          exp_hs[n+i] = 1'b0;
          exp_vs[n+i] = 1'b0;
        end
        exp_rst[n+1] = 1'b1;
      end
    end else begin
      chk("cycle_budget", 32'(n), 32'(N - 4));
    end
    @(posedge clk);
    #1;
  endtask

  // Ramp line; output j sits at position j*step and is produced by the first
  // input pixel at or beyond that position, mixing it with its left neighbour.
  task automatic run_line(input int stp, input int w, input int gap, input bit use_hs,
                          input int abort_at, input bit v, output int n_exp);
    bit         em [0:1023];
    logic [7:0] ev [0:1023];
    logic [7:0] px [0:1023];
    int eff, pos, k, f, coe, prv;
    got.delete();
    for (int i = 0; i < 1024; i++) begin
      px[i] = 8'(i);
      em[i] = 1'b0;
      ev[i] = '0;
    end
    eff   = use_hs ? ((stp < PS) ? PS : stp) : PS;
    n_exp = 0;
    for (int j = 0; j * eff <= (w - 1) * PS; j++) begin
      pos = j * eff;
      k   = (pos + PS - 1) / PS;
      f   = pos - k * PS + PS;
      coe = f * 256 / PS;
      prv = (k > 0) ? int'(px[k-1]) : 0;
      em[k] = 1'b1;
      ev[k] = 8'((prv * (256 - coe) + int'(px[k]) * coe + 128) >> 8);
      n_exp++;
    end
    for (int i = 0; i < w; i++) begin
      if (i == abort_at) begin
        drive(1'b1, 1'b1, 1'b0, 1'b1, px[i], 16'd100, 1'b0, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 16'd100, 1'b0, 8'd0);
        return;
      end
      drive(1'b0, 1'b1, use_hs && (i == 0), v, px[i],
            (i == 0) ? 16'(stp) : 16'd100, em[i], ev[i]);
      for (int g = 0; g < gap; g++)
        drive(1'b0, 1'b0, g == 0, v, 8'hA5, 16'd100, 1'b0, 8'd0);
    end
    repeat (4) drive(1'b0, 1'b0, 1'b0, v, 8'd0, 16'd100, 1'b0, 8'd0);
  endtask

  task automatic idle(input int n, input bit v);
    repeat (n) drive(1'b0, 1'b0, 1'b0, v, 8'd0, 16'd0, 1'b0, 8'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < N; i++) begin
      exp_de[i] = 1'b0; exp_hs[i] = 1'b0; exp_vs[i] = 1'b0;
      exp_rst[i] = 1'b0; exp_do[i] = '0;
    end
    repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 8'd0);

    // Pixels before any line start run at the reset ratio (1:1).
    run_line(64, 5, 0, 1'b0, -1, 1'b0, n);
    chk("nohs_model_cnt", 32'(n), 32'd5);
    chk("nohs_cnt", 32'(got.size()), 32'd5);
    chk("nohs_last", 32'(got[4]), 32'd4);

    run_line(64, 600, 0, 1'b1, -1, 1'b0, n);
    chk("s64_model_cnt", 32'(n), 32'd300);
    chk("s64_cnt", 32'(got.size()), 32'd300);
    chk("s64_v1", 32'(got[1]), 32'd2);
    chk("s64_v150", 32'(got[150]), 32'd44);
    chk("s64_v299", 32'(got[299]), 32'd86);

    run_line(32, 600, 0, 1'b1, -1, 1'b0, n);
    chk("s32_model_cnt", 32'(n), 32'd600);
    chk("s32_cnt", 32'(got.size()), 32'd600);
    chk("s32_v300", 32'(got[300]), 32'd44);
    chk("s32_v599", 32'(got[599]), 32'd87);

    run_line(48, 600, 0, 1'b1, -1, 1'b0, n);
    chk("s48_model_cnt", 32'(n), 32'd400);
    chk("s48_cnt", 32'(got.size()), 32'd400);
    chk("s48_v0", 32'(got[0]), 32'd0);
    chk("s48_v1", 32'(got[1]), 32'd2);
    chk("s48_v2", 32'(got[2]), 32'd3);
    chk("s48_v3", 32'(got[3]), 32'd5);
    chk("s48_v4", 32'(got[4]), 32'd6);
    chk("s48_v5", 32'(got[5]), 32'd8);

    run_line(64, 600, 1, 1'b1, -1, 1'b0, n);
    chk("gap1_cnt", 32'(got.size()), 32'd300);
    chk("gap1_v150", 32'(got[150]), 32'd44);

    run_line(64, 600, 3, 1'b1, -1, 1'b0, n);
    chk("gap3_cnt", 32'(got.size()), 32'd300);
    chk("gap3_v299", 32'(got[299]), 32'd86);

    run_line(0, 40, 0, 1'b1, -1, 1'b0, n);
    chk("s0_cnt", 32'(got.size()), 32'd40);
    chk("s0_v39", 32'(got[39]), 32'd39);

    run_line(16, 40, 0, 1'b1, -1, 1'b0, n);
    chk("s16_cnt", 32'(got.size()), 32'd40);
    chk("s16_v17", 32'(got[17]), 32'd17);

    // Reset mid-line, then two full frames.
    idle(3, 1'b1);
    run_line(64, 600, 0, 1'b1, 200, 1'b0, n);
    chk("rst_kept_cnt", 32'(got.size()), 32'd99);
    idle(2, 1'b0);
    for (int fr = 0; fr < 2; fr++) begin
      idle(3, 1'b1);
      for (int ln = 0; ln < 2; ln++) begin
        run_line(64, 600, 0, 1'b1, -1, 1'b0, n);
        chk("frame_cnt", 32'(got.size()), 32'd300);
        chk("frame_v299", 32'(got[299]), 32'd86);
      end
    end
    idle(6, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_scaler_h.md
# video_scaler_h

Horizontal video scaler. It resamples each active line of a single-component pixel stream by a run-time ratio using 2-tap linear interpolation. It sits in the video pipeline between a sync-qualified pixel source and downstream vertical scaling or output logic. It supports downscaling and 1:1, and passes line and frame sync through with fixed latency.

## Interface
- PIXEL_STEP, 32: fixed-point unit of one input pixel. Power of two, ≤ 2^COE_WIDTH.
- PIXEL_WIDTH, 8: bits per pixel.
- COE_WIDTH, 8: interpolation coefficient fraction bits.
- clk  in  1  sole clock.
- rst  in  1  reset, synchronous, active-high.
- scale_step_h  in  16  input advance per output pixel, in units of 1/PIXEL_STEP input pixel (ratio × PIXEL_STEP).
- di_i  in  PIXEL_WIDTH  input pixel.
- de_i  in  1  input pixel valid.
- hs_i  in  1  line-start pulse, coincident with the first de_i of a line.
- vs_i  in  1  frame sync level, passed through.
- do_o  out  PIXEL_WIDTH  output pixel.
- de_o  out  1  output pixel valid.
- hs_o  out  1  high with the first de_o of each output line.
- vs_o  out  1  vs_i delayed.

## Operation
- The step value is step = max(scale_step_h, PIXEL_STEP). Values below PIXEL_STEP, including 0, are treated as 1:1. Upscaling is not supported.
- step is sampled on hs_i & de_i and held constant for the whole line.
- Line state:
  - xpos (24 b): position of the current input pixel.
  - acc (24 b): position of the next output pixel.
  - prev: the previous input pixel.
- On hs_i & de_i: xpos = 0, acc = 0, and this pixel is pixel 0.
- For each de_i pixel k (xpos = k·PIXEL_STEP):
  - Emit one output if acc ≤ xpos; otherwise emit nothing.
  - f = acc − xpos + PIXEL_STEP, with f in (0, PIXEL_STEP].
  - coe = f · 2^COE_WIDTH / PIXEL_STEP. This is COE_WIDTH+1 bits, with range 1..2^COE_WIDTH.
  - do = (prev·(2^COE_WIDTH − coe) + cur·coe + 2^(COE_WIDTH−1)) >> COE_WIDTH. This rounds half up. The result never exceeds the pixel maximum, so no saturation is needed.
  - After an emit: acc += step.
  - After every pixel: xpos += PIXEL_STEP and prev = cur.
- Pixel 0 always emits with coe = 2^COE_WIDTH, so do = di.
- Outputs per line: floor((W−1)·PIXEL_STEP/step) + 1.
- de_i gaps of any length are allowed. State holds while de_i = 0.
- hs_i without de_i is ignored.
- de_i before the first hs_i uses the current (reset) state.
- Multiply widths: PIXEL_WIDTH × (COE_WIDTH+1), summed at PIXEL_WIDTH+COE_WIDTH+2 bits.

## Timing
- Fixed 3-cycle latency from de_i to de_o, do_o, hs_o and vs_o:
  - stage 1: compare and coefficient computation;
  - stage 2: the two products;
  - stage 3: sum, round and output register.
- hs_o is hs_i & de_i delayed 3 cycles. It therefore coincides with the first de_o of the line.
- vs_o is vs_i delayed 3 cycles, regardless of de_i.
- de_o = 0 for non-emitting pixels and during gaps. do_o holds its last value when de_o = 0.
- Reset values: do_o = 0, de_o = 0, hs_o = 0, vs_o = 0; all pipeline stages cleared; xpos = acc = prev = 0; step = PIXEL_STEP.
- Reset mid-line:
  - Outputs are 0 from the next cycle.
  - Pixels already in flight are discarded.
  - Processing resumes on the next hs_i & de_i.

## Structure
- Package scaler_pkg holds:
  - localparam POS_WIDTH = 24;
  - the derived COE_SHIFT = log2(2^COE_WIDTH/PIXEL_STEP);
  - a pipeline-stage struct {de, hs, vs, prev, cur, coe}.
- One sub-module, scaler_h_lerp. It is the 2-stage weighted sum and rounding datapath, parameterized by PIXEL_WIDTH and COE_WIDTH.
- Position and emit control stay in the top module.

## Test plan
- Ramp di = x mod 256, W = 600, scale_step_h = 64, no de gaps -> 300 outputs per line: 0,2,4,…,598 mod 256. hs_o coincides with the first de_o; latency is exactly 3.
- Same ramp, scale_step_h = 32 -> 600 outputs identical to the input, delayed 3 cycles.
- Same ramp, scale_step_h = 48 -> 400 outputs, the first six being 0,2,3,5,6,8 (half-pixel positions round up).
- scale_step_h = 64 with one or three idle cycles between pixels -> same output sequence as without gaps; each de_o occurs 3 cycles after its source de_i.
- scale_step_h = 0 or 16 -> behaves as 32 (1:1).
- Assert rst mid-line -> all outputs 0 on the next cycle. Release before the next line; the following line and frame (two frames run) produce the full expected sequence, and vs_o tracks vs_i with a 3-cycle delay.
